// File: rtl/sweep_counter.sv
// Sweep generator: ramps a value between programmable bounds in up-only,
// down-only or triangle mode, for a programmable number of sweeps.
// A start pulse latches the configuration. Hold freezes the sweep. Abort
// returns to idle without a done pulse.
module sweep_counter #(
   parameter int WIDTH  = 4,
   parameter int LOOP_W = 4
) (
   input  logic              in_clock,
   input  logic              in_reset,
   input  logic              in_start,
   input  logic [1:0]        in_mode,
   input  logic [WIDTH-1:0]  in_low,
   input  logic [WIDTH-1:0]  in_high,
   input  logic [WIDTH-1:0]  in_step,
   input  logic [LOOP_W-1:0] in_loops,
   input  logic              in_hold,
   input  logic              in_abort,
   output logic              out_ready,
   output logic [WIDTH-1:0]  out_value,
   output logic              out_dir,
   output logic              out_done,
   output logic              out_error
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } state_t;

   state_t              r_state;
   logic [WIDTH-1:0]    r_value;
   logic                r_dir;
   logic                r_done;
   logic                r_error;
   logic [LOOP_W-1:0]   r_loop_cnt;

   // Configuration captured on the accepted start edge
   logic [1:0]          r_mode;
   logic [WIDTH-1:0]    r_low;
   logic [WIDTH-1:0]    r_high;
   logic [WIDTH-1:0]    r_step;
   logic [LOOP_W-1:0]   r_loops;

   logic                w_mode_up;
   logic                w_mode_down;
   logic                w_mode_tri;
   logic [WIDTH:0]      w_sum;
   logic [WIDTH:0]      w_low_lim;
   logic [WIDTH-1:0]    w_up_step;
   logic [WIDTH-1:0]    w_dn_step;
   logic [WIDTH-1:0]    w_next;
   logic [WIDTH-1:0]    w_term;
   logic                w_complete;
   logic [LOOP_W-1:0]   w_cnt_inc;
   logic                w_final;
   logic                w_cfg_bad;
   state_t              w_next_state;

   assign w_mode_up   = (r_mode == 2'b00);
   assign w_mode_down = (r_mode == 2'b01);
   assign w_mode_tri  = r_mode[1];

   // One extra bit on both comparisons so a step past either bound clamps
   // to the bound instead of wrapping around.
   assign w_sum     = {1'b0, r_value} + {1'b0, r_step};
   assign w_low_lim = {1'b0, r_low} + {1'b0, r_step};
   assign w_up_step = (w_sum >= {1'b0, r_high}) ? r_high : w_sum[WIDTH-1:0];
   assign w_dn_step = ({1'b0, r_value} < w_low_lim) ? r_low : (r_value - r_step);

   // Next value on an active cycle. Single-direction modes sitting on their
   // terminal value reload the start value. This only happens after a
   // completed, non-final sweep, or when low equals high.
   always_comb begin
      w_next = w_dn_step;
      if (r_state == ST_UP) begin
         if (w_mode_up && (r_value == r_high)) begin
            w_next = r_low;
         end else begin
            w_next = w_up_step;
         end
      end else begin
         if (w_mode_down && (r_value == r_low)) begin
            w_next = r_high;
         end else begin
            w_next = w_dn_step;
         end
      end
   end

   // A sweep completes on the edge that loads its terminal value
   assign w_term     = w_mode_up ? r_high : r_low;
   assign w_complete = (w_next == w_term);
   assign w_cnt_inc  = r_loop_cnt + 1'b1;
   assign w_final    = (r_loops != '0) && (w_cnt_inc == r_loops);
   assign w_cfg_bad  = (in_low > in_high) || (in_step == '0);

   // Triangle direction turns at the bounds. When low equals high the
   // sweep stays in UP and each pass is a single cycle at the bound.
   always_comb begin
      w_next_state = r_state;
      if (w_mode_tri) begin
         if ((r_state == ST_UP) && (w_next == r_high) && (r_low != r_high)) begin
            w_next_state = ST_DOWN;
         end else if ((r_state == ST_DOWN) && (w_next == r_low)) begin
            w_next_state = ST_UP;
         end
      end
   end

   // Main sweep state machine with registered outputs
   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         r_state    <= ST_IDLE;
         r_value    <= '0;
         r_dir      <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_loop_cnt <= '0;
         r_mode     <= 2'b00;
         r_low      <= '0;
         r_high     <= '0;
         r_step     <= '0;
         r_loops    <= '0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         if (r_state == ST_IDLE) begin
            if (in_abort) begin
               r_dir <= 1'b0;
            end else if (!in_hold) begin
               r_dir <= 1'b0;
               if (in_start) begin
                  if (w_cfg_bad) begin
                     r_error <= 1'b1;
                  end else begin
                     r_mode     <= in_mode;
                     r_low      <= in_low;
                     r_high     <= in_high;
                     r_step     <= in_step;
                     r_loops    <= in_loops;
                     r_loop_cnt <= '0;
                     if (in_mode == 2'b01) begin
                        r_value <= in_high;
                        r_dir   <= 1'b0;
                        r_state <= ST_DOWN;
                     end else begin
                        r_value <= in_low;
                        r_dir   <= 1'b1;
                        r_state <= ST_UP;
                     end
                  end
               end
            end
         end else begin
            if (in_abort) begin
               r_state <= ST_IDLE;
               r_dir   <= 1'b0;
            end else if (!in_hold) begin
               r_value <= w_next;
               if (w_complete) begin
                  r_loop_cnt <= w_cnt_inc;
               end
               if (w_complete && w_final) begin
                  // Direction is left as it was for the done cycle and
                  // cleared on the following idle cycle.
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= w_next_state;
                  r_dir   <= (w_next_state == ST_UP);
               end
            end
         end
      end
   end

   assign out_ready = (r_state == ST_IDLE);
   assign out_value = r_value;
   assign out_dir   = r_dir;
   assign out_done  = r_done;
   assign out_error = r_error;

endmodule

// File: tb/tb_sweep_counter.sv
// Bench for sweep_counter. A queue-based reference expands each accepted
// sweep into its list of values. It is checked against the DUT on every
// falling edge and pinned by literal sequences.
module tb_sweep_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_start = 1'b0;
   logic [1:0] in_mode = 2'b00;
   logic [3:0] in_low = 4'd0;
   logic [3:0] in_high = 4'd0;
   logic [3:0] in_step = 4'd0;
   logic [3:0] in_loops = 4'd0;
   logic       in_hold = 1'b0;
   logic       in_abort = 1'b0;
   logic       out_ready;
   logic [3:0] out_value;
   logic       out_dir;
   logic       out_done;
   logic       out_error;

   sweep_counter #(.WIDTH(4), .LOOP_W(4)) dut (
      .in_clock (clk),
      .in_reset (rst),
      .in_start (in_start),
      .in_mode  (in_mode),
      .in_low   (in_low),
      .in_high  (in_high),
      .in_step  (in_step),
      .in_loops (in_loops),
      .in_hold  (in_hold),
      .in_abort (in_abort),
      .out_ready(out_ready),
      .out_value(out_value),
      .out_dir  (out_dir),
      .out_done (out_done),
      .out_error(out_error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit started  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int v;
      bit d;
      bit c;
   } ent_t;

   ent_t m_q[$];
   int   m_value = 0;
   bit   m_dir = 0, m_done = 0, m_error = 0, m_busy = 0;
   int   m_cnt = 0;
   int   m_mode = 0, m_low = 0, m_high = 0, m_step = 1, m_loops = 0;

   task automatic push(input int v, input bit d, input bit c);
      ent_t e;
      e.v = v; e.d = d; e.c = c;
      m_q.push_back(e);
   endtask

   // Values visited walking from 'from' to 'to' in clamped steps, excluding 'from'
   task automatic ramp(input int from, input int to, input bit d_mid, input bit d_last, input bit c_last);
      int v;
      v = from;
      do begin
         if (to >= from) v = (v + m_step >= to) ? to : v + m_step;
         else            v = (v - m_step <= to) ? to : v - m_step;
         if (v == to) push(v, d_last, c_last);
         else         push(v, d_mid, 1'b0);
      end while (v != to);
   endtask

   task automatic add_first_sweep();
      if (m_mode == 0) begin
         ramp(m_low, m_high, 1, 1, 1);
      end else if (m_mode == 1) begin
         ramp(m_high, m_low, 0, 0, 1);
      end else if (m_low == m_high) begin
         ramp(m_low, m_high, 1, 1, 1);
      end else begin
         ramp(m_low, m_high, 1, 0, 0);
         ramp(m_high, m_low, 0, 1, 1);
      end
   endtask

   task automatic add_next_sweep();
      if (m_mode == 0) begin
         if (m_low == m_high) push(m_low, 1, 1);
         else begin push(m_low, 1, 0); ramp(m_low, m_high, 1, 1, 1); end
      end else if (m_mode == 1) begin
         if (m_low == m_high) push(m_low, 0, 1);
         else begin push(m_high, 0, 0); ramp(m_high, m_low, 0, 0, 1); end
      end else begin
         add_first_sweep();
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_value = 0; m_dir = 0; m_done = 0; m_error = 0; m_busy = 0; m_cnt = 0;
         m_q.delete();
      end else begin
         ent_t e;
         m_done  = 0;
         m_error = 0;
         if (!m_busy) begin
            if (in_abort) begin
               m_dir = 0;
            end else if (!in_hold) begin
               m_dir = 0;
               if (in_start) begin
                  if (in_low > in_high || in_step == 0) begin
                     m_error = 1;
                  end else begin
                     m_mode = int'(in_mode); m_low = int'(in_low); m_high = int'(in_high);
                     m_step = int'(in_step); m_loops = int'(in_loops);
                     m_cnt = 0; m_busy = 1;
                     m_q.delete();
                     add_first_sweep();
                     m_value = (m_mode == 1) ? m_high : m_low;
                     m_dir   = (m_mode != 1);
                  end
               end
            end
         end else if (in_abort) begin
            m_busy = 0; m_dir = 0;
            m_q.delete();
         end else if (!in_hold) begin
            if (m_q.size() == 0) add_next_sweep();
            e = m_q.pop_front();
            m_value = e.v;
            if (e.c) m_cnt++;
            if (e.c && m_loops != 0 && m_cnt == m_loops) begin
               m_busy = 0; m_done = 1;
               m_q.delete();
            end else begin
               m_dir = e.d;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (started && !rst) begin
         chk("value", 32'(out_value), 32'(m_value));
         chk("dir",   32'(out_dir),   32'(m_dir));
         chk("done",  32'(out_done),  32'(m_done));
         chk("error", 32'(out_error), 32'(m_error));
         chk("ready", 32'(out_ready), 32'(!m_busy));
      end
   end

   // ---------------- directed helpers ----------------
   int lit[$];

   // Called at a falling edge; issues one start and releases it after the edge
   task automatic start_cfg(input int mode, input int lo, input int hi, input int st, input int lp);
      in_mode = 2'(mode); in_low = 4'(lo); in_high = 4'(hi);
      in_step = 4'(st); in_loops = 4'(lp); in_start = 1'b1;
      @(posedge clk);
      #2;
      in_start = 1'b0;
      in_low = 4'($urandom); in_high = 4'($urandom);
      in_step = 4'($urandom); in_loops = 4'($urandom); in_mode = 2'($urandom);
   endtask

   task automatic run_seq(input string name, input int n, input bit exp_done, input int dir_exp);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk({name, "_value"}, 32'(m_value), 32'(lit[i]));
         chk({name, "_done"},  32'(m_done),  32'(exp_done && i == n - 1));
         if (dir_exp >= 0) chk({name, "_dir"}, 32'(m_dir), 32'(dir_exp));
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_value", 32'(out_value), 32'd0);
      chk("reset_ready", 32'(out_ready), 32'd1);
      chk("reset_dir",   32'(out_dir),   32'd0);
      chk("reset_done",  32'(out_done),  32'd0);
      chk("reset_error", 32'(out_error), 32'd0);
      rst = 1'b0;
      started = 1'b1;
      @(negedge clk);

      // triangle 0..15..0, legacy-equivalent
      lit.delete();
      for (int v = 0; v <= 15; v++) lit.push_back(v);
      for (int v = 14; v >= 0; v--) lit.push_back(v);
      start_cfg(2, 0, 15, 1, 1);
      run_seq("tri_full", 31, 1, -1);
      $display("tri_full: 31 values swept");
      @(negedge clk);

      // up-only with clamped final step
      lit = '{2, 5, 8, 9};
      start_cfg(0, 2, 9, 3, 1);
      run_seq("up_clamp", 4, 1, 1);
      $display("up_clamp: 2,5,8,9");
      @(negedge clk);

      // up-only, two sweeps, single done
      lit = '{0, 1, 2, 3, 0, 1, 2, 3};
      start_cfg(0, 0, 3, 1, 2);
      run_seq("up_two", 8, 1, 1);
      $display("up_two: two sweeps");
      @(negedge clk);

      // down-only continuous, aborted
      lit = '{7, 5, 3, 1, 7, 5};
      start_cfg(1, 1, 7, 2, 0);
      run_seq("down_cont", 6, 0, 0);
      in_abort = 1'b1;
      @(negedge clk);
      in_abort = 1'b0;
      chk("abort_value", 32'(m_value), 32'd5);
      chk("abort_busy",  32'(m_busy),  32'd0);
      chk("abort_done",  32'(m_done),  32'd0);
      $display("down_cont: aborted at 5");

      // triangle with 3-cycle hold mid-ramp
      lit = '{2, 3, 4};
      start_cfg(2, 2, 6, 1, 1);
      run_seq("hold_pre", 3, 0, 1);
      in_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_value", 32'(m_value), 32'd4);
         chk("hold_dir",   32'(m_dir),   32'd1);
      end
      in_hold = 1'b0;
      lit = '{5, 6, 5, 4, 3, 2};
      run_seq("hold_post", 6, 1, -1);
      $display("hold: resumed after 3 frozen cycles");
      @(negedge clk);

      // rejected configurations
      start_cfg(0, 5, 4, 1, 1);
      @(negedge clk);
      chk("bad_bounds_err",  32'(m_error), 32'd1);
      chk("bad_bounds_busy", 32'(m_busy),  32'd0);
      @(negedge clk);
      chk("bad_bounds_pulse", 32'(m_error), 32'd0);
      start_cfg(2, 1, 9, 0, 1);
      @(negedge clk);
      chk("bad_step_err",  32'(m_error), 32'd1);
      chk("bad_step_busy", 32'(m_busy),  32'd0);
      $display("errors: bad bounds and zero step rejected");
      @(negedge clk);

      // asynchronous reset mid-sweep
      start_cfg(2, 0, 15, 1, 0);
      repeat (5) @(negedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_value", 32'(out_value), 32'd0);
      chk("async_rst_ready", 32'(out_ready), 32'd1);
      chk("async_rst_dir",   32'(out_dir),   32'd0);
      @(negedge clk);
      #1 rst = 1'b0;
      $display("reset: asynchronous clear mid-sweep");

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         in_start = ($urandom % 4 == 0);
         in_mode  = 2'($urandom);
         in_low   = 4'($urandom);
         if ($urandom % 8 == 0) in_high = 4'($urandom);
         else in_high = 4'($urandom_range(int'(in_low), 15));
         in_step  = ($urandom % 16 == 0) ? 4'd0 : 4'($urandom_range(1, 5));
         in_loops = 4'($urandom % 4);
         in_hold  = ($urandom % 10 == 0);
         in_abort = ($urandom % 40 == 0);
      end
      @(negedge clk);
      in_start = 1'b0; in_hold = 1'b0; in_abort = 1'b0;
      repeat (2) @(negedge clk);
      $display("random: 3000 cycles applied");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
